// File: rtl/rvfpm_xif_result_queue.sv
// In-order result buffer between the FPU pipeline and the XIF result channel.
// Define RVFPM_XIF_RESULT_BYPASS_EN to present results to the result channel in the push cycle.
module rvfpm_xif_result_queue #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFW_WIDTH = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic [X_ID_WIDTH-1:0]         push_id,
  input  logic [X_RFW_WIDTH-1:0]        push_data,
  input  logic [4:0]                    push_rd,
  input  logic [X_RFW_WIDTH/XLEN-1:0]   push_we,
  input  logic                          push_exc,
  input  logic [5:0]                    push_exccode,
  input  logic                          commit_valid,
  input  logic [X_ID_WIDTH-1:0]         commit_id,
  input  logic                          commit_kill,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [X_ID_WIDTH-1:0]         result_id,
  output logic [X_RFW_WIDTH-1:0]        result_data,
  output logic [4:0]                    result_rd,
  output logic [X_RFW_WIDTH/XLEN-1:0]   result_we,
  output logic                          result_exc,
  output logic [5:0]                    result_exccode,
  output logic [5:0]                    result_ecsdata,
  output logic [2:0]                    result_ecswe,
  output logic                          result_err,
  output logic                          result_dbg,
  output logic [$clog2(DEPTH):0]        cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WE_W  = X_RFW_WIDTH / XLEN;
  localparam int unsigned N_ID  = 2 ** X_ID_WIDTH;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic [WE_W-1:0]        we;
    logic                   exc;
    logic [5:0]             exccode;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             push_e, head, res, out_e;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt_d;
  logic [N_ID-1:0]    ok_q, kill_q, ok_d, kill_d;
  logic               occupied, drop, present, bypass, bypass_fire, push_fire, pop;

  assign push_e = '{id: push_id, data: push_data, rd: push_rd, we: push_we,
                    exc: push_exc, exccode: push_exccode};
  assign head   = mem[rd_ptr];
  assign push_ready = (cnt < CNT_W'(DEPTH));

  // Head evaluation against the registered commit table; kill takes priority over ok.
  always_comb begin
    occupied = (cnt != '0);
    drop     = occupied && kill_q[head.id];
    present  = occupied && !kill_q[head.id] && ok_q[head.id];
    bypass   = 1'b0;
    res      = head;
`ifdef RVFPM_XIF_RESULT_BYPASS_EN
    if (!occupied && push_valid && ok_q[push_id]) begin
      bypass = 1'b1;
      res    = push_e;
    end
`endif
    result_valid = present || bypass;
    pop          = drop || (present && result_ready);
    bypass_fire  = bypass && result_ready;
    push_fire    = push_valid && push_ready && !bypass_fire;
  end

  assign out_e          = result_valid ? res : '0;
  assign result_id      = out_e.id;
  assign result_data    = out_e.data;
  assign result_rd      = out_e.rd;
  assign result_we      = out_e.we;
  assign result_exc     = out_e.exc;
  assign result_exccode = out_e.exccode;
  assign result_ecsdata = '0;
  assign result_ecswe   = '0;
  assign result_err     = 1'b0;
  assign result_dbg     = 1'b0;

  // Retiring an ID clears its bits; a same-cycle commit to that ID is applied last so it wins.
  always_comb begin
    ok_d   = ok_q;
    kill_d = kill_q;
    if (pop) begin
      ok_d[head.id]   = 1'b0;
      kill_d[head.id] = 1'b0;
    end
    if (bypass_fire) begin
      ok_d[push_id]   = 1'b0;
      kill_d[push_id] = 1'b0;
    end
    if (commit_valid) begin
      if (commit_kill) kill_d[commit_id] = 1'b1;
      else             ok_d[commit_id]   = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt;
    if (push_fire && !pop)      cnt_d = cnt + CNT_W'(1);
    else if (!push_fire && pop) cnt_d = cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ok_q   <= '0;
      kill_q <= '0;
    end else begin
      cnt    <= cnt_d;
      ok_q   <= ok_d;
      kill_q <= kill_d;
      if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_e;
  end

`ifndef SYNTHESIS
  // Pushing into a full queue loses the entry.
  always @(posedge clk) begin
    if (!rst) assert (!(push_valid && !push_ready));
  end
`endif

endmodule

// File: tb/tb_rvfpm_xif_result_queue.sv
// Self-checking bench for rvfpm_xif_result_queue: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_rvfpm_xif_result_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned N_ID  = 16;
`ifdef RVFPM_XIF_RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid, push_ready;
  logic [3:0]  push_id;
  logic [31:0] push_data;
  logic [4:0]  push_rd;
  logic [0:0]  push_we;
  logic        push_exc;
  logic [5:0]  push_exccode;
  logic        commit_valid, commit_kill;
  logic [3:0]  commit_id;
  logic        result_valid, result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic [0:0]  result_we;
  logic        result_exc, result_err, result_dbg;
  logic [5:0]  result_exccode, result_ecsdata;
  logic [2:0]  result_ecswe;
  logic [2:0]  cnt;

  rvfpm_xif_result_queue dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_id(push_id),
    .push_data(push_data), .push_rd(push_rd), .push_we(push_we),
    .push_exc(push_exc), .push_exccode(push_exccode),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_id(result_id), .result_data(result_data), .result_rd(result_rd),
    .result_we(result_we), .result_exc(result_exc), .result_exccode(result_exccode),
    .result_ecsdata(result_ecsdata), .result_ecswe(result_ecswe),
    .result_err(result_err), .result_dbg(result_dbg), .cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [0:0]  we;
    logic        exc;
    logic [5:0]  exccode;
  } ent_t;

  // Reference model: in-order list of pending results plus per-ID commit flags.
  ent_t q[$];
  bit   ok_m[N_ID];
  bit   kill_m[N_ID];
  bit   m_valid, m_drop, m_byp, m_push_ready;
  ent_t m_res;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int emitted[$];
  int emitted_cyc[$];

  logic        obs_valid, obs_push_ready;
  logic [3:0]  obs_id;
  logic [31:0] obs_data;
  logic [4:0]  obs_rd;
  logic [2:0]  obs_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: evaluate the model, compare outputs, then advance model on the edge.
  task automatic tick();
    ent_t pe;
    #1;
    m_push_ready = (q.size() < DEPTH);
    m_valid = 1'b0; m_drop = 1'b0; m_byp = 1'b0;
    m_res = '{default: '0};
    if (q.size() > 0) begin
      if (kill_m[q[0].id]) m_drop = 1'b1;
      else if (ok_m[q[0].id]) begin
        m_valid = 1'b1;
        m_res   = q[0];
      end
    end
    pe = '{push_id, push_data, push_rd, push_we, push_exc, push_exccode};
    if (BYP && q.size() == 0 && push_valid && ok_m[push_id]) begin
      m_valid = 1'b1;
      m_byp   = 1'b1;
      m_res   = pe;
    end

    obs_valid = result_valid; obs_push_ready = push_ready; obs_id = result_id;
    obs_data = result_data; obs_rd = result_rd; obs_cnt = cnt;
    chk("push_ready", push_ready, m_push_ready);
    chk("cnt", cnt, q.size());
    chk("result_valid", result_valid, m_valid);
    if (m_valid) begin
      chk("result_id", result_id, m_res.id);
      chk("result_data", result_data, m_res.data);
      chk("result_rd", result_rd, m_res.rd);
      chk("result_we", result_we, m_res.we);
      chk("result_exc", {result_exc, result_exccode}, {m_res.exc, m_res.exccode});
    end
    chk("tied_zero", {result_ecsdata, result_ecswe, result_err, result_dbg}, 0);
    if (result_valid && result_ready) begin
      emitted.push_back(int'(result_id));
      emitted_cyc.push_back(cyc);
    end

    @(posedge clk);
    if (rst) begin
      q.delete();
      for (int i = 0; i < N_ID; i++) begin ok_m[i] = 1'b0; kill_m[i] = 1'b0; end
    end else begin
      if (m_drop || (m_valid && !m_byp && result_ready)) begin
        ok_m[q[0].id]   = 1'b0;
        kill_m[q[0].id] = 1'b0;
        void'(q.pop_front());
      end
      if (m_byp && result_ready) begin
        ok_m[push_id]   = 1'b0;
        kill_m[push_id] = 1'b0;
      end else if (push_valid && m_push_ready) begin
        q.push_back(pe);
      end
      if (commit_valid) begin
        if (commit_kill) kill_m[commit_id] = 1'b1;
        else             ok_m[commit_id]   = 1'b1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    push_valid = 1'b0;
    commit_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd);
    push_valid = 1'b1; push_id = id; push_data = data; push_rd = rd;
    push_we = 1'b1; push_exc = 1'b0; push_exccode = '0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1; commit_id = id; commit_kill = kill;
  endtask

  initial begin
    logic        v0, v1;
    logic [31:0] d0, d1;
    logic [3:0]  i0, i1;
    logic [4:0]  r0, r1;

    rst = 1'b1; result_ready = 1'b0;
    push_valid = 1'b0; push_id = '0; push_data = '0; push_rd = '0; push_we = '0;
    push_exc = 1'b0; push_exccode = '0;
    commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // Reset state
    tick();
    chk("rst_cnt", obs_cnt, 0);
    chk("rst_push_ready", obs_push_ready, 1);
    chk("rst_valid", obs_valid, 0);
    chk("rst_fields", {obs_id, obs_data, obs_rd}, 0);

    // Commit before push: result one cycle after the push (same cycle with bypass)
    result_ready = 1'b1;
    commit(4'd3, 1'b0); tick();
    idle(); push(4'd3, 32'h3F80_0000, 5'd5); tick();
    v0 = obs_valid; d0 = obs_data; i0 = obs_id; r0 = obs_rd;
    idle(); tick();
    v1 = obs_valid; d1 = obs_data; i1 = obs_id; r1 = obs_rd;
    chk("t1_valid_push_cycle", v0, BYP);
    chk("t1_valid_next_cycle", v1, !BYP);
    chk("t1_data", BYP ? d0 : d1, 32'h3F80_0000);
    chk("t1_id", BYP ? i0 : i1, 3);
    chk("t1_rd", BYP ? r0 : r1, 5);
    tick();
    chk("t1_cnt_zero", obs_cnt, 0);

    // Kill in the middle: IDs 1 and 3 emitted, one-cycle gap for the dropped ID 2
    push(4'd1, 32'h11, 5'd1); tick();
    push(4'd2, 32'h22, 5'd2); tick();
    push(4'd3, 32'h33, 5'd3); tick();
    idle();
    emitted.delete(); emitted_cyc.delete();
    commit(4'd1, 1'b0); tick();
    commit(4'd2, 1'b1); tick();
    commit(4'd3, 1'b0); tick();
    idle(); repeat (3) tick();
    chk("t2_count", emitted.size(), 2);
    chk("t2_first", emitted.size() > 0 ? emitted[0] : -1, 1);
    chk("t2_second", emitted.size() > 1 ? emitted[1] : -1, 3);
    chk("t2_gap", emitted.size() > 1 ? emitted_cyc[1] - emitted_cyc[0] : -1, 2);
    chk("t2_cnt_zero", obs_cnt, 0);

    // Late commit: head waits until the cycle after the commit
    push(4'd7, 32'h77, 5'd7); tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_wait_valid", obs_valid, 0);
    end
    commit(4'd7, 1'b0); tick();
    chk("t3_commit_cycle_valid", obs_valid, 0);
    idle(); tick();
    chk("t3_after_commit_valid", obs_valid, 1);
    chk("t3_after_commit_id", obs_id, 7);

    // Fill to capacity, then release the head
    push(4'd8, 32'h88, 5'd8); tick();
    push(4'd9, 32'h99, 5'd9); tick();
    push(4'd10, 32'hAA, 5'd10); tick();
    push(4'd11, 32'hBB, 5'd11); tick();
    idle(); tick();
    chk("t4_full_ready", obs_push_ready, 0);
    chk("t4_full_cnt", obs_cnt, 4);
    commit(4'd8, 1'b0); tick();
    idle(); tick();
    chk("t4_head_valid", obs_valid, 1);
    chk("t4_head_id", obs_id, 8);
    chk("t4_still_full", obs_push_ready, 0);
    tick();
    chk("t4_ready_again", obs_push_ready, 1);
    chk("t4_cnt_after_pop", obs_cnt, 3);
    commit(4'd9, 1'b1); tick();
    commit(4'd10, 1'b1); tick();
    commit(4'd11, 1'b1); tick();
    idle(); repeat (4) tick();
    chk("t4_drained", obs_cnt, 0);

    // Backpressure: fields hold while ready is low, exactly one pop when raised
    result_ready = 1'b0;
    commit(4'd12, 1'b0); tick();
    idle(); push(4'd12, 32'hC0FF_EE12, 5'd12); tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", obs_valid, 1);
      chk("t5_hold_data", obs_data, 32'hC0FF_EE12);
      chk("t5_hold_rd", obs_rd, 12);
    end
    result_ready = 1'b1; tick();
    chk("t5_release_valid", obs_valid, 1);
    tick();
    chk("t5_after_valid", obs_valid, 0);
    chk("t5_after_cnt", obs_cnt, 0);

    // Reset with entries queued and commit bits set
    result_ready = 1'b0;
    commit(4'd2, 1'b0); push(4'd1, 32'h101, 5'd1); tick();
    commit(4'd5, 1'b0); push(4'd2, 32'h102, 5'd2); tick();
    idle(); push(4'd3, 32'h103, 5'd3); tick();
    idle(); tick();
    chk("t6_pre_cnt", obs_cnt, 3);
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    chk("t6_rst_cnt", obs_cnt, 0);
    chk("t6_rst_valid", obs_valid, 0);
    chk("t6_rst_ready", obs_push_ready, 1);
    result_ready = 1'b1;
    push(4'd2, 32'h202, 5'd2); tick();
    chk("t6_push_valid", obs_valid, 0);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_stale_commit_valid", obs_valid, 0);
    end
    commit(4'd2, 1'b0); tick();
    idle(); tick();
    chk("t6_fresh_commit_valid", obs_valid, 1);
    chk("t6_fresh_commit_data", obs_data, 32'h202);
    tick();
    chk("t6_drained", obs_cnt, 0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      push_valid   = ($urandom_range(0, 99) < 50) && (q.size() < DEPTH);
      push_id      = 4'($urandom_range(0, 15));
      push_data    = $urandom;
      push_rd      = 5'($urandom_range(0, 31));
      push_we      = 1'($urandom_range(0, 1));
      push_exc     = 1'($urandom_range(0, 1));
      push_exccode = 6'($urandom_range(0, 63));
      commit_valid = ($urandom_range(0, 99) < 40);
      commit_id    = 4'($urandom_range(0, 15));
      commit_kill  = ($urandom_range(0, 99) < 25);
      result_ready = ($urandom_range(0, 99) < 70);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
